// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mult_share_arbiter_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req_valid bit at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W:0] pos;

  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[pos[ID_W-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 multiplier among NUM_REQ clients.
// Optional WAIT watchdog enabled by defining MULT_TIMEOUT_EN.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OP_W*NUM_REQ-1:0]   req_mplier,
  input  logic [OP_W*NUM_REQ-1:0]   req_mcand,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]         rsp_result,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      mul_st,
  output logic [OP_W-1:0]           mul_mplier,
  output logic [OP_W-1:0]           mul_mcand,
  input  logic                      mul_done,
  input  logic [PROD_W-1:0]         mul_result
);

  state_e          state, state_n;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            seen_low;
  logic            done_ok;
  logic            to_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // A done only counts after a low has been seen, so a stale high from the last op is skipped.
  assign done_ok = mul_done && seen_low;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      if (!to_hit) to_cnt <= to_cnt + 1'b1;
      if (done_ok)     err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
    end
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign to_hit         = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    mul_st    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_any) begin
          // Masked during reset so every output reads 0 while rst is high.
          req_ready[pick_idx] = !rst;
          state_n             = ISSUE;
        end
      end
      ISSUE: begin
        mul_st  = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (done_ok || to_hit) state_n = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        state_n            = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      mul_mplier <= '0;
      mul_mcand  <= '0;
      seen_low   <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            mul_mplier <= req_mplier[pick_idx*OP_W +: OP_W];
            mul_mcand  <= req_mcand[pick_idx*OP_W +: OP_W];
          end
        end
        ISSUE: seen_low <= 1'b0;
        WAIT: begin
          if (!mul_done) seen_low <= 1'b1;
          if (done_ok || to_hit) rsp_id <= grant_q;
          if (done_ok)     rsp_result <= mul_result;
          else if (to_hit) rsp_result <= '0;
        end
        RESP: rr_ptr <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter; the bench also plays the multiplier.
module tb_mult_share_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int ID_W           = 2;
  localparam int TIMEOUT_CYCLES = 8;

  logic                    Clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [8*NUM_REQ-1:0]    req_mplier;
  logic [8*NUM_REQ-1:0]    req_mcand;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [15:0]             rsp_result;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_err;
  logic                    busy;
  logic                    mul_st;
  logic [7:0]              mul_mplier;
  logic [7:0]              mul_mcand;
  logic                    mul_done;
  logic [15:0]             mul_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  mult_share_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .Clk        (Clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_mplier (req_mplier),
    .req_mcand  (req_mcand),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mul_st     (mul_st),
    .mul_mplier (mul_mplier),
    .mul_mcand  (mul_mcand),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    req_mplier[id*8 +: 8] = a;
    req_mcand[id*8 +: 8]  = b;
  endtask

  // Entered in an IDLE cycle with the request already driven; returns in the following IDLE cycle.
  task automatic do_txn(input int id, input logic [15:0] exp_prod, input int low_cycles, input bit drop);
    logic [7:0] a;
    logic [7:0] b;
    #1;
    check("ready", 32'(req_ready), 32'(1 << id));
    tick();
    check("mul_st_issue", 32'(mul_st), 32'd1);
    check("busy_issue", 32'(busy), 32'd1);
    check("ready_clear", 32'(req_ready), 32'd0);
    a = mul_mplier;
    b = mul_mcand;
    if (drop) req_valid[id] = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      tick();
      check("mul_st_wait", 32'(mul_st), 32'd0);
      check("busy_wait", 32'(busy), 32'd1);
      check("no_early_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    mul_result = {8'h00, a} * {8'h00, b};
    mul_done   = 1'b1;
    check("no_early_rsp", 32'(rsp_valid), 32'd0);
    tick();
    mul_done = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'(1 << id));
    check("rsp_result", 32'(rsp_result), 32'(exp_prod));
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_err", 32'(rsp_err), 32'd0);
    check("busy_resp", 32'(busy), 32'd1);
    tick();
    check("rsp_strobe_1cyc", 32'(rsp_valid), 32'd0);
    check("rsp_hold", 32'(rsp_result), 32'(exp_prod));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_mplier = '0;
    req_mcand  = '0;
    mul_done   = 1'b0;
    mul_result = '0;
    set_req(0, 8'd12, 8'd11);
    req_valid = 4'b0001;
    repeat (3) tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_st", 32'(mul_st), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mplier", 32'(mul_mplier), 32'd0);
    check("rst_mcand", 32'(mul_mcand), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    rst = 1'b0;
    do_txn(0, 16'd132, 1, 1'b1);

    // Reset during WAIT; rr_ptr is 1 at this point.
    set_req(2, 8'd3, 8'd5);
    req_valid = 4'b0100;
    #1;
    check("rw_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    check("rw_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_mul_st", 32'(mul_st), 32'd0);
    check("rw_mplier", 32'(mul_mplier), 32'd0);
    check("rw_rsp_result", 32'(rsp_result), 32'd0);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    mul_done   = 1'b1;
    mul_result = 16'd15;
    tick();
    tick();
    check("rw_rsp_valid_held", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("rw_rsp_after", 32'(rsp_valid), 32'd0);
    check("rw_busy_after", 32'(busy), 32'd0);
    mul_done = 1'b0;
    tick();

    // All four requesting continuously: order 0,1,2,3,0.
    set_req(0, 8'd255, 8'd255);
    set_req(1, 8'd0,   8'd200);
    set_req(2, 8'd1,   8'd1);
    set_req(3, 8'd13,  8'd7);
    req_valid = 4'b1111;
    do_txn(0, 16'hFE01, 1, 1'b0);
    do_txn(1, 16'd0,    2, 1'b0);
    do_txn(2, 16'd1,    1, 1'b0);
    do_txn(3, 16'd91,   3, 1'b0);
    do_txn(0, 16'hFE01, 1, 1'b0);
    req_valid = '0;
    tick();

    // Stale done held high into WAIT; rr_ptr is 1.
    set_req(1, 8'd9, 8'd9);
    mul_done   = 1'b1;
    mul_result = 16'hDEAD;
    req_valid  = 4'b0010;
    #1;
    check("st_ready", 32'(req_ready), 32'b0010);
    tick();
    check("st_mul_st", 32'(mul_st), 32'd1);
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_no_early", 32'(rsp_valid), 32'd0);
      check("st_busy", 32'(busy), 32'd1);
    end
    tick();
    mul_done = 1'b0;
    check("st_no_early", 32'(rsp_valid), 32'd0);
    tick();
    mul_done   = 1'b1;
    mul_result = 16'd81;
    check("st_no_early", 32'(rsp_valid), 32'd0);
    tick();
    mul_done = 1'b0;
    check("st_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("st_rsp_result", 32'(rsp_result), 32'd81);
    check("st_rsp_id", 32'(rsp_id), 32'd1);
    tick();
    check("st_idle", 32'(busy), 32'd0);

`ifdef MULT_TIMEOUT_EN
    // done stuck low: RESP TIMEOUT_CYCLES cycles after entering WAIT, then requester 3 served.
    set_req(2, 8'd4, 8'd4);
    set_req(3, 8'd2, 8'd3);
    req_valid = 4'b1100;
    #1;
    check("to_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
      tick();
      check("to_no_early", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("to_rsp_valid", 32'(rsp_valid), 32'b0100);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_result", 32'(rsp_result), 32'd0);
    check("to_rsp_id", 32'(rsp_id), 32'd2);
    tick();
    do_txn(3, 16'd6, 1, 1'b1);
`else
    // Without the watchdog a long done latency is simply waited out.
    set_req(2, 8'd4, 8'd4);
    req_valid = 4'b0100;
    do_txn(2, 16'd16, 12, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one sequential 8x8 multiplier (start/done handshake, 16-bit product) among NUM_REQ requesters.
- Uses round-robin arbitration: captures the winner's operands, pulses start, waits for done, then returns the product to the winner with a one-cycle response strobe.
- Sits between client blocks and the multiplier instance; the multiplier's I/O is registered, so done latency is arbitrary but at least 2 cycles after start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of granted-requester index; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only when MULT_TIMEOUT_EN is defined.

Ports:
- Clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_mplier  in  8*NUM_REQ  packed multipliers; requester i occupies bits [8i+7:8i].
- req_mcand  in  8*NUM_REQ  packed multiplicands, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot result strobe, 1 cycle.
- rsp_result  out  16  product for the strobed requester.
- rsp_id  out  ID_W  index of the strobed requester.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- busy  out  1  high whenever state != IDLE.
- mul_st  out  1  start pulse to the multiplier.
- mul_mplier  out  8  operand to the multiplier.
- mul_mcand  out  8  operand to the multiplier.
- mul_done  in  1  multiplier done.
- mul_result  in  16  multiplier product.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all outputs 0, latched operands 0, grant index 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the grant is the first set bit searching from rr_ptr upward with wrap (rr_ptr itself has highest priority).
  - req_ready[grant]=1 combinationally in this cycle only. Operands and grant index are registered at the edge; next state is ISSUE.
  - If no request, stay in IDLE.
- ISSUE: mul_st=1 for exactly one cycle; clear the seen_low flag; go to WAIT.
- WAIT:
  - mul_st=0. mul_mplier/mul_mcand hold the latched operands from ISSUE until RESP exits.
  - seen_low is set on any cycle where mul_done=0.
  - Completion is the first cycle with mul_done=1 and seen_low=1. This rejects a stale Done still high from the previous operation.
  - On completion, latch mul_result and go to RESP.
- RESP:
  - rsp_valid[grant]=1, rsp_id=grant, rsp_result=latched product, rsp_err as set.
  - rr_ptr <= (grant+1) mod NUM_REQ; next state IDLE.
  - rsp_result and rsp_id hold their values until the next RESP.
- Responses have no backpressure; clients must sample on rsp_valid.
- Latency: accept at cycle T; mul_st at T+1; rsp_valid at D+1, where D is the first qualifying done cycle. Minimum total is 4 cycles with the pipelined multiplier.
- A requester may drop req_valid before it is granted; no request is lost or duplicated once accepted.
- req_valid held continuously by the same requester: it is re-granted only after the other pending requesters have each been served once.
- Product width: 16 bits, unsigned, passed through unmodified.
- Reset asserted mid-operation: everything returns to the reset state asynchronously. The in-flight result is discarded and no rsp_valid is issued. The multiplier is reset in parallel by the same rst.
- mul_done high outside WAIT is ignored.

Optional Feature:
- MULT_TIMEOUT_EN defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without completion, go to RESP with rsp_result=16'h0000 and rsp_err=1.
  - The counter clears in ISSUE.
- Not defined: no counter is built, rsp_err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - operand width 8 and product width 16.
- Sub-module rr_pick(NUM_REQ): pure combinational round-robin selector; inputs req_valid and rr_ptr; outputs grant_idx and any_valid.

Test Plan:
- Single request: req_valid=4'b0001, operands 8'd12 x 8'd11 -> req_ready[0] pulses once; one mul_st pulse; rsp_valid=4'b0001, rsp_result=16'd132, rsp_id=0.
- All four requesting continuously with rr_ptr=0 -> grant order 0,1,2,3,0; each rsp_result matches that requester's operands, e.g. 255x255 -> 16'hFE01.
- Stale done: mul_done held high from before ISSUE and not dropping until 5 cycles later -> completion only on the first high after the low; rsp_valid does not fire early.
- Reset asserted in WAIT -> all outputs 0 immediately and no rsp_valid afterwards; a new request after release is accepted with rr_ptr=0.
- Edge operands: 0x200 and 1x1 -> rsp_result 16'd0 and 16'd1; busy is high from ISSUE through RESP.
- MULT_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mul_done stuck at 0 -> RESP fires 8 cycles after entering WAIT with rsp_err=1 and rsp_result=0, then the next requester is served normally.
